// File: rtl/reg_bus_initiator.sv
// Register-bank bus initiator: takes one read/write command over a
// valid/ready handshake, strobes the shared bus, returns a response.
// Ports:
//   SYS_CLK, rst(async, low)   clock / reset
//   cmd_valid/ready/write/addr/wdata   command handshake and payload
//   rsp_valid/ready/write/err/rdata    response handshake and payload
//   amba_addr, read_flag, write_flag, bus_wdata, bus_rdata   register bus
module reg_bus_initiator #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_COUNT  = 16
) (
  input  logic                  SYS_CLK,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [DATA_WIDTH-1:0] amba_addr,
  output logic                  read_flag,
  output logic                  write_flag,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  // When the register count covers the whole address space,
  // no address can be out of range.
  localparam bit ALL_LEGAL =
    ($clog2(REG_COUNT + 1) > DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] LIMIT =
    DATA_WIDTH'(REG_COUNT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                  r_cmd_write;
  logic [DATA_WIDTH-1:0] r_amba_addr;
  logic [DATA_WIDTH-1:0] r_bus_wdata;
  logic                  r_read_flag;
  logic                  r_write_flag;
  logic                  r_rsp_valid;
  logic                  r_rsp_write;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic                  w_cmd_write_nxt;
  logic [DATA_WIDTH-1:0] w_amba_addr_nxt;
  logic [DATA_WIDTH-1:0] w_bus_wdata_nxt;
  logic                  w_read_flag_nxt;
  logic                  w_write_flag_nxt;
  logic                  w_rsp_valid_nxt;
  logic                  w_rsp_write_nxt;
  logic                  w_rsp_err_nxt;
  logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
  logic                  w_in_range;

  assign w_in_range = ALL_LEGAL || (cmd_addr < LIMIT);

  always_ff @(posedge SYS_CLK or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cmd_write  <= 1'b0;
      r_amba_addr  <= '0;
      r_bus_wdata  <= '0;
      r_read_flag  <= 1'b0;
      r_write_flag <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_write  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_rdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cmd_write  <= w_cmd_write_nxt;
      r_amba_addr  <= w_amba_addr_nxt;
      r_bus_wdata  <= w_bus_wdata_nxt;
      r_read_flag  <= w_read_flag_nxt;
      r_write_flag <= w_write_flag_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_write  <= w_rsp_write_nxt;
      r_rsp_err    <= w_rsp_err_nxt;
      r_rsp_rdata  <= w_rsp_rdata_nxt;
    end
  end

  // Strobes default low so each lasts exactly the ACCESS cycle;
  // everything else holds unless a state updates it.
  always_comb begin
    w_state_nxt      = r_state;
    w_cmd_write_nxt  = r_cmd_write;
    w_amba_addr_nxt  = r_amba_addr;
    w_bus_wdata_nxt  = r_bus_wdata;
    w_read_flag_nxt  = 1'b0;
    w_write_flag_nxt = 1'b0;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_write_nxt  = r_rsp_write;
    w_rsp_err_nxt    = r_rsp_err;
    w_rsp_rdata_nxt  = r_rsp_rdata;
    unique case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_cmd_write_nxt = cmd_write;
          if (w_in_range) begin
            w_state_nxt      = ACCESS;
            w_amba_addr_nxt  = cmd_addr;
            if (cmd_write) w_bus_wdata_nxt = cmd_wdata;
            w_read_flag_nxt  = ~cmd_write;
            w_write_flag_nxt = cmd_write;
          end else begin
            w_state_nxt     = RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_write_nxt = cmd_write;
            w_rsp_rdata_nxt = '0;
          end
        end
      end
      ACCESS: begin
        if (r_cmd_write) begin
          w_state_nxt     = RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_write_nxt = 1'b1;
          w_rsp_rdata_nxt = '0;
        end else begin
          w_state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        // Bank data_out was refreshed at the ACCESS edge.
        w_state_nxt     = RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_write_nxt = 1'b0;
        w_rsp_rdata_nxt = bus_rdata;
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = IDLE;
          w_rsp_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign cmd_ready  = (r_state == IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_write  = r_rsp_write;
  assign rsp_err    = r_rsp_err;
  assign rsp_rdata  = r_rsp_rdata;
  assign amba_addr  = r_amba_addr;
  assign read_flag  = r_read_flag;
  assign write_flag = r_write_flag;
  assign bus_wdata  = r_bus_wdata;

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Directed bench for reg_bus_initiator with a small register-bank model.
// Reset values of bank entry i are 0x40+i.
module tb_reg_bus_initiator;

  localparam int DW = 8;

  logic          SYS_CLK;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [DW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_write;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [DW-1:0] amba_addr;
  logic          read_flag;
  logic          write_flag;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;

  int checks   = 0;
  int failures = 0;
  int wf_cnt   = 0;
  int rf_cnt   = 0;
  int both_cnt = 0;
  int wf_snap;
  int rf_snap;

  logic [DW-1:0] mem [16];

  reg_bus_initiator #(.DATA_WIDTH(DW), .REG_COUNT(16)) dut (
    .SYS_CLK    (SYS_CLK),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_write  (rsp_write),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .amba_addr  (amba_addr),
    .read_flag  (read_flag),
    .write_flag (write_flag),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata)
  );

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  always @(posedge SYS_CLK or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(8'h40 + i);
      bus_rdata <= '0;
    end else begin
      if (write_flag) mem[amba_addr[3:0]] <= bus_wdata;
      if (read_flag) bus_rdata <= mem[amba_addr[3:0]];
    end
  end

  always @(negedge SYS_CLK) begin
    if (write_flag) wf_cnt++;
    if (read_flag) rf_cnt++;
    if (write_flag && read_flag) both_cnt++;
  end

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic w,
                     input logic [DW-1:0] a,
                     input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_write"}, 32'(rsp_write), 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
    chk({tag, "_rflag"}, 32'(read_flag), 0);
    chk({tag, "_wflag"}, 32'(write_flag), 0);
    chk({tag, "_addr"}, 32'(amba_addr), 0);
    chk({tag, "_wdata"}, 32'(bus_wdata), 0);
    chk({tag, "_rdata"}, 32'(rsp_rdata), 0);
  endtask

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    chk_reset("rst");
    rst = 1'b1;
    tick();

    // Write addr 3 = 0xA5
    cmd(1'b1, 8'd3, 8'hA5);
    wf_snap = wf_cnt;
    tick();
    chk("w1_wflag", 32'(write_flag), 1);
    chk("w1_rflag", 32'(read_flag), 0);
    chk("w1_addr", 32'(amba_addr), 3);
    chk("w1_wdata", 32'(bus_wdata), 32'hA5);
    chk("w1_cmd_ready", 32'(cmd_ready), 0);
    chk("w1_vld_early", 32'(rsp_valid), 0);
    cmd_valid = 1'b0;
    tick();
    chk("w1_wflag_off", 32'(write_flag), 0);
    chk("w1_vld", 32'(rsp_valid), 1);
    chk("w1_err", 32'(rsp_err), 0);
    chk("w1_rw", 32'(rsp_write), 1);
    chk("w1_rdata", 32'(rsp_rdata), 0);
    tick();
    chk("w1_vld_done", 32'(rsp_valid), 0);
    chk("w1_ready", 32'(cmd_ready), 1);
    chk("w1_strobes", 32'(wf_cnt - wf_snap), 1);

    // Read addr 3
    cmd(1'b0, 8'd3, 8'h00);
    rf_snap = rf_cnt;
    tick();
    chk("r1_rflag", 32'(read_flag), 1);
    chk("r1_addr", 32'(amba_addr), 3);
    cmd_valid = 1'b0;
    tick();
    chk("r1_rflag_off", 32'(read_flag), 0);
    chk("r1_vld_early", 32'(rsp_valid), 0);
    tick();
    chk("r1_vld", 32'(rsp_valid), 1);
    chk("r1_rdata", 32'(rsp_rdata), 32'hA5);
    chk("r1_rw", 32'(rsp_write), 0);
    chk("r1_err", 32'(rsp_err), 0);
    tick();
    chk("r1_vld_done", 32'(rsp_valid), 0);
    chk("r1_strobes", 32'(rf_cnt - rf_snap), 1);

    // Out-of-range read addr 20 and write addr 16
    wf_snap = wf_cnt;
    rf_snap = rf_cnt;
    cmd(1'b0, 8'd20, 8'h00);
    tick();
    chk("e1_vld", 32'(rsp_valid), 1);
    chk("e1_err", 32'(rsp_err), 1);
    chk("e1_rdata", 32'(rsp_rdata), 0);
    chk("e1_rw", 32'(rsp_write), 0);
    chk("e1_rflag", 32'(read_flag), 0);
    cmd_valid = 1'b0;
    tick();
    chk("e1_vld_done", 32'(rsp_valid), 0);
    cmd(1'b1, 8'd16, 8'hFF);
    tick();
    chk("e2_vld", 32'(rsp_valid), 1);
    chk("e2_err", 32'(rsp_err), 1);
    chk("e2_rw", 32'(rsp_write), 1);
    cmd_valid = 1'b0;
    tick();
    chk("e_no_wstrobe", 32'(wf_cnt - wf_snap), 0);
    chk("e_no_rstrobe", 32'(rf_cnt - rf_snap), 0);

    // Highest legal address
    cmd(1'b1, 8'd15, 8'h5A);
    tick();
    chk("b15_wflag", 32'(write_flag), 1);
    chk("b15_addr", 32'(amba_addr), 15);
    cmd_valid = 1'b0;
    tick();
    chk("b15_err", 32'(rsp_err), 0);
    chk("b15_vld", 32'(rsp_valid), 1);
    tick();

    // Read addr 7 with response stalled, second command pending
    rsp_ready = 1'b0;
    cmd(1'b0, 8'd7, 8'h00);
    tick();
    chk("s_rflag", 32'(read_flag), 1);
    cmd(1'b1, 8'd9, 8'h99);
    tick();
    chk("s_capture_ready", 32'(cmd_ready), 0);
    tick();
    chk("s_vld", 32'(rsp_valid), 1);
    chk("s_rdata", 32'(rsp_rdata), 32'h47);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s_hold_vld", 32'(rsp_valid), 1);
      chk("s_hold_rdata", 32'(rsp_rdata), 32'h47);
      chk("s_hold_ready", 32'(cmd_ready), 0);
      chk("s_hold_wflag", 32'(write_flag), 0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("s_hs_vld", 32'(rsp_valid), 0);
    chk("s_hs_wflag", 32'(write_flag), 0);
    chk("s_hs_ready", 32'(cmd_ready), 1);
    tick();
    chk("s2_wflag", 32'(write_flag), 1);
    chk("s2_addr", 32'(amba_addr), 9);
    chk("s2_wdata", 32'(bus_wdata), 32'h99);
    cmd_valid = 1'b0;
    tick();
    chk("s2_vld", 32'(rsp_valid), 1);
    chk("s2_rw", 32'(rsp_write), 1);
    tick();

    // Back-to-back write then read of addr 1
    cmd(1'b1, 8'd1, 8'h11);
    tick();
    chk("bb_wflag", 32'(write_flag), 1);
    cmd(1'b0, 8'd1, 8'h00);
    tick();
    chk("bb_wvld", 32'(rsp_valid), 1);
    tick();
    chk("bb_hs_vld", 32'(rsp_valid), 0);
    chk("bb_hs_rflag", 32'(read_flag), 0);
    tick();
    chk("bb_rflag", 32'(read_flag), 1);
    chk("bb_raddr", 32'(amba_addr), 1);
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("bb_rvld", 32'(rsp_valid), 1);
    chk("bb_rdata", 32'(rsp_rdata), 32'h11);
    tick();

    // Reset during a write ACCESS cycle
    cmd(1'b1, 8'd4, 8'h77);
    tick();
    chk("ra_wflag", 32'(write_flag), 1);
    wf_snap = wf_cnt;
    rf_snap = rf_cnt;
    cmd_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk_reset("ra");
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("ra_rel_ready", 32'(cmd_ready), 1);
    chk("ra_no_wstrobe", 32'(wf_cnt - wf_snap), 0);
    chk("ra_rel_vld", 32'(rsp_valid), 0);
    cmd(1'b0, 8'd2, 8'h00);
    tick();
    chk("ra_rflag", 32'(read_flag), 1);
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("ra_vld", 32'(rsp_valid), 1);
    chk("ra_rdata", 32'(rsp_rdata), 32'h42);
    chk("ra_err", 32'(rsp_err), 0);
    tick();
    chk("ra_no_wstrobe2", 32'(wf_cnt - wf_snap), 0);
    chk("ra_rstrobes", 32'(rf_cnt - rf_snap), 1);
    chk("never_both", 32'(both_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bus_initiator.md
Name: reg_bus_initiator

Overview:
- Bus-side initiator that drives the shared register-bank interface, i.e. the read_flag, write_flag, amba_addr and data lines sampled by each general-purpose register.
- Accepts one read or write command at a time from a local controller over a valid/ready handshake.
- Performs the register access, captures read data one cycle after the access cycle, and returns a response over a second valid/ready handshake.
- Flags out-of-range addresses as errors without touching the bus.

Parameters:
DATA_WIDTH, 8, width of address, write data and read data
REG_COUNT, 16, number of implemented registers; legal addresses are 0..REG_COUNT-1

Ports:
SYS_CLK  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
cmd_valid  input  1  command present
cmd_ready  output  1  initiator can accept a command
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  DATA_WIDTH  target register address
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_write  output  1  echo of cmd_write for this response
rsp_err  output  1  address was out of range
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors
amba_addr  output  DATA_WIDTH  bus address to register bank
read_flag  output  1  bus read strobe
write_flag  output  1  bus write strobe
bus_wdata  output  DATA_WIDTH  bus write data (register data_in)
bus_rdata  input  DATA_WIDTH  bus read data (register data_out)

Behaviour:
- Reset values while rst=0:
  - State IDLE; cmd_ready=1.
  - rsp_valid, rsp_write, rsp_err, read_flag, write_flag = 0.
  - amba_addr, bus_wdata, rsp_rdata = 0.
  - Reset takes effect immediately. An access or response in progress is abandoned and no strobe is emitted afterwards.
- All outputs except cmd_ready are registered. cmd_ready = (state==IDLE), combinational from state only.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE:
  - If cmd_valid at the edge, latch write/addr/wdata.
  - If addr < REG_COUNT: go to ACCESS, and in the same edge drive amba_addr=addr, bus_wdata=wdata (writes only), and read_flag=~write or write_flag=write.
  - If addr >= REG_COUNT: go directly to RESP with rsp_err=1, rsp_write=cmd_write, rsp_rdata=0. No strobe is issued.
- ACCESS:
  - Exactly one cycle with one strobe high. The strobes are never high together.
  - On exit, clear both strobes. amba_addr and bus_wdata hold their last value.
  - Read goes to CAPTURE; write goes to RESP with rsp_err=0, rsp_rdata=0.
- CAPTURE:
  - One cycle; the register bank updates its data_out at the ACCESS-cycle edge.
  - At the edge ending CAPTURE, rsp_rdata <= bus_rdata, rsp_err=0, rsp_write=0; go to RESP.
- RESP:
  - rsp_valid=1 and response fields held stable until rsp_ready is sampled 1; then rsp_valid=0 and go to IDLE.
  - A new command is not accepted in the same edge as the response handshake. The earliest acceptance is the following edge.
- Latency from the command-accept edge to rsp_valid high:
  - Write: 2 edges.
  - Read: 3 edges.
  - Error: 1 edge.
- Throughput: at most one outstanding command. cmd_valid is ignored outside IDLE.
- Commands are never dropped or duplicated. Each accepted command produces exactly one response.
- The address compare is unsigned at full DATA_WIDTH. If REG_COUNT >= 2^DATA_WIDTH, no address errors.

Test Plan:
- Reset, then write addr 3 data 0xA5 with rsp_ready=1 -> write_flag high exactly 1 cycle with amba_addr=3, bus_wdata=0xA5; rsp_valid 2 edges after accept, rsp_err=0, rsp_write=1, rsp_rdata=0.
- Read addr 3 with a bench register model returning 0xA5 one cycle after read_flag -> read_flag 1 cycle; rsp_valid 3 edges after accept, rsp_rdata=0xA5, rsp_write=0.
- Read addr 20 (REG_COUNT=16) -> no strobe ever asserted; rsp_valid 1 edge after accept, rsp_err=1, rsp_rdata=0.
- Read addr 7 with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata held stable; cmd_ready=0 throughout; a second cmd_valid is ignored until 1 cycle after the handshake.
- Back-to-back write 0x11 to addr 1 then read addr 1, cmd_valid held high -> second command accepted on the edge after the first response handshake; read returns 0x11.
- Assert rst=0 during the ACCESS cycle of a write -> write_flag drops immediately, all outputs go to reset values, no further strobe; after release, cmd_ready=1 and a new read completes normally.
